// File: rtl/sobel_disp_pkg.sv
// Shared geometry defaults, width helpers and display FSM state type for the Sobel display path.
package sobel_disp_pkg;
    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;
    localparam int SCALE_DEF = 4;

    function automatic int addr_w(input int w, input int h);
        return (w * h <= 2) ? 1 : $clog2(w * h);
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ADDR_W_DEF = addr_w(IMG_W_DEF, IMG_H_DEF);

    typedef enum logic [1:0] {WAIT_DONE, WAIT_FRAME, DISPLAY} disp_state_e;
endpackage

// File: rtl/pixel_fetch_if.sv
// Frame-buffer read port: the fetcher issues rd_en/rd_addr, the buffer returns rd_data one cycle later.
interface pixel_fetch_if #(parameter int ADDR_W = sobel_disp_pkg::ADDR_W_DEF);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (output rd_en, rd_addr, input rd_data);
    modport slave  (input rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/pix_addr_gen.sv
// Incremental frame-buffer address for a SCALE-times replicated image: (y/SCALE)*IMG_W + x/SCALE
// built from sub-pixel counters, a column counter and a line-base register.
module pix_addr_gen
    import sobel_disp_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int SCALE  = SCALE_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              adv,
    input  logic              line_end,
    output logic [ADDR_W-1:0] addr
);
    localparam int SW = cnt_w(SCALE);
    localparam int CW = cnt_w(IMG_W);

    logic [SW-1:0]     sx_q, sx_c, sx_d, sy_q, sy_c, sy_d;
    logic [CW-1:0]     col_q, col_c, col_d;
    logic [ADDR_W-1:0] base_q, base_c, base_d;

    always_comb begin
        // Frame start overrides stored position so the (0,0) tick itself reads address 0.
        sx_c   = frame_start ? '0 : sx_q;
        sy_c   = frame_start ? '0 : sy_q;
        col_c  = frame_start ? '0 : col_q;
        base_c = frame_start ? '0 : base_q;
        sx_d   = sx_c;
        sy_d   = sy_c;
        col_d  = col_c;
        base_d = base_c;
        if (adv) begin
            if (line_end) begin
                sx_d  = '0;
                col_d = '0;
                if (sy_c == SW'(SCALE - 1)) begin
                    sy_d   = '0;
                    base_d = base_c + ADDR_W'(IMG_W);
                end else begin
                    sy_d = sy_c + 1'b1;
                end
            end else if (sx_c == SW'(SCALE - 1)) begin
                sx_d  = '0;
                col_d = col_c + 1'b1;
            end else begin
                sx_d = sx_c + 1'b1;
            end
        end
    end

    assign addr = base_c + ADDR_W'(col_c);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sx_q   <= '0;
            sy_q   <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            col_q  <= col_d;
            base_q <= base_d;
        end
    end
endmodule

// File: rtl/pixel_fetch.sv
// Streams the Sobel frame buffer to the VGA output stage with SCALE-times pixel replication.
// Define PIXEL_FETCH_THRESH_EN to binarise pixels against THRESHOLD instead of truncating to 4 bits.
module pixel_fetch
    import sobel_disp_pkg::*;
#(
    parameter int         IMG_W     = IMG_W_DEF,
    parameter int         IMG_H     = IMG_H_DEF,
    parameter int         SCALE     = SCALE_DEF,
    parameter logic [7:0] THRESHOLD = 8'd64
) (
    input  logic         clk_100MHz,
    input  logic         reset,
    input  logic         p_tick,
    input  logic         video_on,
    input  logic [9:0]   x,
    input  logic [9:0]   y,
    input  logic         done,
    pixel_fetch_if.master fb,
    output logic [3:0]   red_o,
    output logic [3:0]   green_o,
    output logic [3:0]   blue_o
);
    localparam int          ADDR_W = addr_w(IMG_W, IMG_H);
    localparam int unsigned WIN_W  = IMG_W * SCALE;
    localparam int unsigned WIN_H  = IMG_H * SCALE;
`ifdef PIXEL_FETCH_THRESH_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    disp_state_e       state_q, state_d;
    logic              frame_start, visible, line_end;
    logic              rd_go, blank_go, rd_vld_q, blank_q;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        pix_nib, rgb_q;

    assign frame_start = p_tick && (x == '0) && (y == '0);
    assign visible     = video_on && (32'(x) < WIN_W) && (32'(y) < WIN_H);
    assign line_end    = (32'(x) == WIN_W - 1);

    pix_addr_gen #(.IMG_W(IMG_W), .SCALE(SCALE), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk_100MHz,
        .reset,
        .frame_start,
        .adv (p_tick && visible),
        .line_end,
        .addr
    );

    always_comb begin
        state_d  = state_q;
        rd_go    = 1'b0;
        blank_go = 1'b0;
        case (state_q)
            WAIT_DONE:  if (done) state_d = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) state_d = done ? DISPLAY : WAIT_DONE;
            DISPLAY:    if (frame_start && !done) state_d = WAIT_DONE;
            default:    state_d = WAIT_DONE;
        endcase
        // Keying on the next state lets the frame-start tick that enters DISPLAY fetch pixel (0,0).
        if (p_tick && !reset && state_d == DISPLAY) begin
            rd_go    = visible;
            blank_go = !visible;
        end
    end

    assign fb.rd_en   = rd_go;
    assign fb.rd_addr = addr;
    assign pix_nib    = THRESH_EN ? ((fb.rd_data >= THRESHOLD) ? 4'hF : 4'h0) : fb.rd_data[7:4];

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q  <= WAIT_DONE;
            rd_vld_q <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_go;
            blank_q  <= blank_go;
        end
    end

    // Leaving DISPLAY blanks the output and drops any read still in flight.
    always_ff @(posedge clk_100MHz) begin
        if (reset || state_q != DISPLAY) rgb_q <= '0;
        else if (rd_vld_q)               rgb_q <= pix_nib;
        else if (blank_q)                rgb_q <= '0;
    end

    assign red_o   = rgb_q;
    assign green_o = rgb_q;
    assign blue_o  = rgb_q;
endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch on a reduced 8x6 image (32x24 window) inside a 36x28 raster.
module tb_pixel_fetch;
    localparam int IMG_W = 8, IMG_H = 6, SCALE = 4;
    localparam int WIN_W = IMG_W * SCALE, WIN_H = IMG_H * SCALE;
    localparam int H_VIS = 34, V_VIS = 26, H_TOT = 36, V_TOT = 28;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int RST_X = 20, RST_Y = 12;

    typedef enum {M_WD, M_WF, M_DISP} mst_e;
    typedef struct {int due; logic [3:0] rgb;} sb_t;

    logic              clk_100MHz, reset, p_tick, video_on, done;
    logic [9:0]        x, y;
    logic [3:0]        red_o, green_o, blue_o;

    pixel_fetch_if #(.ADDR_W(ADDR_W)) fb();

    pixel_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .THRESHOLD(8'd64)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .done(done), .fb(fb.master),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    logic [7:0] mem [NPIX];
    always @(posedge clk_100MHz)
        if (fb.rd_en) fb.rd_data <= (int'(fb.rd_addr) < NPIX) ? mem[fb.rd_addr] : 8'h00;

    int   n_cmp = 0, n_bad = 0, cyc_n = 0;
    bit   armed = 0;
    mst_e m_st = M_WD;
    sb_t  sb[$];
    logic [3:0] exp_rgb = 4'h0;
    int   n_rd, n_out, first_addr, last_addr, a59_due = -1;
    int   hits [NPIX];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc_n, act, exp);
        end
    endtask

    function automatic logic [3:0] conv(input logic [7:0] d);
`ifdef PIXEL_FETCH_THRESH_EN
        return (d >= 8'd64) ? 4'hF : 4'h0;
`else
        return d[7:4];
`endif
    endfunction

    task automatic step(input bit tk, input bit rst, input bit dn, input int xx, input int yy);
        bit   von, win, fs, go;
        mst_e nx;
        int   ea;
        sb_t  it;
        @(posedge clk_100MHz); #1;
        cyc_n++;
        von = (xx < H_VIS) && (yy < V_VIS);
        win = von && (xx < WIN_W) && (yy < WIN_H);
        fs  = tk && xx == 0 && yy == 0;
        p_tick = tk; video_on = von; x = 10'(xx); y = 10'(yy); reset = rst; done = dn;
        nx = m_st;
        case (m_st)
            M_WD:    if (dn) nx = M_WF;
            M_WF:    if (fs) nx = dn ? M_DISP : M_WD;
            default: if (fs && !dn) nx = M_WD;
        endcase
        go = tk && win && nx == M_DISP && !rst;
        ea = (yy / SCALE) * IMG_W + xx / SCALE;
        if (tk && !rst) begin
            it.due = cyc_n + 2;
            it.rgb = go ? conv(mem[ea]) : 4'h0;
            sb.push_back(it);
            if (go && xx == 5 && yy == 9) a59_due = cyc_n + 2;
        end
        @(negedge clk_100MHz);
        while (sb.size() > 0 && sb[0].due <= cyc_n) begin
            it = sb.pop_front();
            exp_rgb = it.rgb;
        end
        if (armed) begin
            chk("rd_en", 32'(fb.rd_en), 32'(go));
            if (go) chk("rd_addr", 32'(fb.rd_addr), ea);
            if (go && xx == 5 && yy == 9) chk("addr_5_9", 32'(fb.rd_addr), 17);
            chk("red", 32'(red_o), 32'(exp_rgb));
            chk("green", 32'(green_o), 32'(exp_rgb));
            chk("blue", 32'(blue_o), 32'(exp_rgb));
            if (cyc_n == a59_due) chk("rgb_5_9", 32'(red_o), 32'(conv(8'hA7)));
        end
        if (fb.rd_en) begin
            n_rd++;
            if (n_rd == 1) first_addr = int'(fb.rd_addr);
            last_addr = int'(fb.rd_addr);
            if (!win) n_out++;
            if (int'(fb.rd_addr) < NPIX) hits[fb.rd_addr]++;
        end
        if (rst) begin
            sb.delete();
            it.due = cyc_n + 1;
            it.rgb = 4'h0;
            sb.push_back(it);
            m_st = M_WD;
        end else begin
            m_st = nx;
        end
    endtask

    task automatic frame(input bit dn0, input int flip_y, input int rst_y);
        n_rd = 0; n_out = 0; first_addr = -1; last_addr = -1;
        foreach (hits[i]) hits[i] = 0;
        for (int yy = 0; yy < V_TOT; yy++)
            for (int xx = 0; xx < H_TOT; xx++)
                for (int k = 0; k < 4; k++)
                    step(k == 0, (yy == rst_y) && (xx == RST_X) && (k == 1),
                         (yy >= flip_y) ? !dn0 : dn0, xx, yy);
    endtask

    initial begin
        int bad16;
        p_tick = 0; video_on = 0; x = '0; y = '0; done = 0; reset = 1;
        foreach (mem[i]) mem[i] = 8'($urandom);
        mem[0] = 8'd63; mem[1] = 8'd64; mem[17] = 8'hA7;

        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        armed = 1;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_rd_en", 32'(fb.rd_en), 0);
        chk("rst_rd_addr", 32'(fb.rd_addr), 0);
        chk("rst_rgb", 32'({red_o, green_o, blue_o}), 0);

        frame(0, 99, 99);
        chk("idle1_reads", n_rd, 0);
        frame(0, 99, 99);
        chk("idle2_reads", n_rd, 0);
        frame(0, 10, 99);
        chk("rise_reads", n_rd, 0);

        frame(1, 99, 99);
        chk("full_reads", n_rd, WIN_W * WIN_H);
        chk("full_first", first_addr, 0);
        chk("full_last", last_addr, NPIX - 1);
        chk("blank_reads", n_out, 0);
        bad16 = 0;
        foreach (hits[i]) if (hits[i] != SCALE * SCALE) bad16++;
        chk("hits16", bad16, 0);

        frame(1, 99, RST_Y);
        chk("rst_frame_reads", n_rd, RST_Y * WIN_W + RST_X + 1);

        frame(1, 99, 99);
        chk("resume_first", first_addr, 0);
        chk("resume_reads", n_rd, WIN_W * WIN_H);

        frame(0, 99, 99);
        chk("exit_reads", n_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
